sample_dma: RTL and testbench
=============================

SAMPLE_DMA -- requirements
Module: sample_dma

Interface
REQ-001 SHALL have parameter AW, default 24, SDRAM word-address width.
REQ-002 SHALL have port clk  in  1  clock (clk_48 domain).
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  in  1  DMA run enable from CPU register.
REQ-005 SHALL have port base  in  AW  ring base word address, aligned to ring size.
REQ-006 SHALL have port size_log2  in  5  ring size = 2^size_log2 words, legal range 1..AW.
REQ-007 SHALL have port rd_off  in  AW  CPU consumer offset within the ring.
REQ-008 SHALL have port wm_level  in  AW  watermark fill level.
REQ-009 SHALL have port fifo_empty  in  1  sample FIFO empty.
REQ-010 SHALL have port fifo_rd  out  1  sample FIFO read pulse.
REQ-011 SHALL have port fifo_data  in  16  sample FIFO data, valid one cycle after fifo_rd.
REQ-012 SHALL have port avalid  out  1  SDRAM request valid.
REQ-013 SHALL have port aready  in  1  SDRAM request accepted.
REQ-014 SHALL have port awe  out  1  SDRAM write select, constant 1.
REQ-015 SHALL have port aaddr  out  AW  SDRAM word address.
REQ-016 SHALL have port adata  out  16  SDRAM write data.
REQ-017 SHALL have port wr_off  out  AW  producer offset: next ring slot to write.
REQ-018 SHALL have port busy  out  1  state is not IDLE.
REQ-019 SHALL have port full  out  1  ring full, DMA stalled.
REQ-020 SHALL have port wm_hit  out  1  fill level >= wm_level.

Function
REQ-021 SHALL use states IDLE, FETCH, LATCH, WRITE.
REQ-022 IDLE->FETCH SHALL occur when en && !fifo_empty && !full; fifo_rd SHALL be high only in the FETCH cycle.
REQ-023 FETCH->LATCH unconditionally; in LATCH, adata SHALL capture fifo_data, and the next state SHALL be WRITE.
REQ-024 In WRITE, avalid SHALL be 1, with aaddr = base | wr_off; aaddr and adata SHALL be stable until aready.
REQ-025 On avalid && aready: wr_off SHALL advance to (wr_off+1) & mask, where mask = 2^size_log2-1; the state SHALL return to IDLE; avalid SHALL drop in the next cycle.
REQ-026 Throughput: one word per 4 cycles when aready is asserted in the first WRITE cycle; FIFO-to-request latency is 3 cycles.
REQ-027 The full flag SHALL be combinational: ((wr_off+1) & mask) == (rd_off & mask); when full, no FETCH SHALL start and no data SHALL be dropped by this block.
REQ-028 Fill level SHALL be (wr_off - rd_off) & mask, computed at AW bits with modulo wrap.
REQ-029 An en rising edge while in IDLE SHALL clear wr_off to 0.
REQ-030 If en falls in FETCH, LATCH or WRITE, the word in flight SHALL complete its SDRAM write, and the block SHALL then stay in IDLE.
REQ-031 A change to base or size_log2 while busy SHALL produce undefined behaviour; software changes them only with en=0 and busy=0.
REQ-032 When rd_off and the aready acceptance change in the same cycle, full SHALL use the registered wr_off and the new rd_off.

Reset
REQ-033 On rst, SHALL set: state=IDLE, fifo_rd=0, avalid=0, adata=0, wr_off=0, wm_hit=0; a reset asserted mid-WRITE SHALL abandon the request immediately.

Configuration
REQ-034 When SAMPLE_DMA_WATERMARK_EN is defined, wm_hit SHALL be registered, updated every cycle from the fill level >= wm_level comparison.
REQ-035 When SAMPLE_DMA_WATERMARK_EN is not defined, wm_hit SHALL be tied to 0, wm_level SHALL be ignored, and no comparator logic SHALL remain.

Verification
REQ-036 size_log2=4, base=0x000100, 3 FIFO words 0x1111/0x2222/0x3333, aready=1 -> writes at 0x000100..0x000102, wr_off=3.
REQ-037 size_log2=2, rd_off=0, 5 words available -> 3 writes only, full=1, FIFO not read further; then rd_off=2 -> 2 more writes at 0x3 and 0x0 (wrap).
REQ-038 aready held low for 10 cycles in WRITE -> avalid stays high, aaddr/adata unchanged, a single write is accepted.
REQ-039 en falls in the LATCH cycle -> that word is still written, then IDLE with busy=0; en rises again -> wr_off=0.
REQ-040 With SAMPLE_DMA_WATERMARK_EN, wm_level=4, rd_off=0 -> wm_hit rises the cycle after the 4th acceptance; without the macro, wm_hit stays 0.
REQ-041 rst asserted while avalid=1 -> the next cycle has avalid=0, state=IDLE, wr_off=0.

Source files
------------

// File: rtl/sample_dma.sv
// sample_dma: moves 16-bit samples from the sample FIFO into an SDRAM ring buffer.
// Define SAMPLE_DMA_WATERMARK_EN to build the registered fill-level watermark flag.
module sample_dma #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] base,
  input  logic [4:0]    size_log2,
  input  logic [AW-1:0] rd_off,
  input  logic [AW-1:0] wm_level,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [15:0]   fifo_data,
  output logic          avalid,
  input  logic          aready,
  output logic          awe,
  output logic [AW-1:0] aaddr,
  output logic [15:0]   adata,
  output logic [AW-1:0] wr_off,
  output logic          busy,
  output logic          full,
  output logic          wm_hit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic          fifo_rd_r;
  logic          avalid_r;
  logic          en_q_r;
  logic [AW-1:0] aaddr_r;
  logic [AW-1:0] wr_off_r;
  logic [15:0]   adata_r;
  logic [AW-1:0] mask_s;
  logic [AW-1:0] wr_next_s;
  logic          full_s;

  // Ring mask of size_log2 low ones; a shift of AW or more leaves all ones.
  assign mask_s    = ~({AW{1'b1}} << size_log2);
  assign wr_next_s = (wr_off_r + ONE) & mask_s;
  assign full_s    = (wr_next_s == (rd_off & mask_s));

  // Transfer sequencer: one FIFO word per pass through FETCH/LATCH/WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      fifo_rd_r <= 1'b0;
      avalid_r  <= 1'b0;
      en_q_r    <= 1'b0;
      aaddr_r   <= {AW{1'b0}};
      adata_r   <= 16'h0000;
      wr_off_r  <= {AW{1'b0}};
    end else begin
      en_q_r <= en;
      case (state_r)
        ST_IDLE: begin
          // A fresh enable restarts the ring; the fetch waits one cycle so
          // the full check sees the cleared producer offset.
          if (en && !en_q_r) begin
            wr_off_r <= {AW{1'b0}};
          end else if (en && !fifo_empty && !full_s) begin
            fifo_rd_r <= 1'b1;
            state_r   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          fifo_rd_r <= 1'b0;
          state_r   <= ST_LATCH;
        end
        ST_LATCH: begin
          adata_r  <= fifo_data;
          aaddr_r  <= base | wr_off_r;
          avalid_r <= 1'b1;
          state_r  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (aready) begin
            avalid_r <= 1'b0;
            wr_off_r <= wr_next_s;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          fifo_rd_r <= 1'b0;
          avalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd = fifo_rd_r;
  assign avalid  = avalid_r;
  assign awe     = 1'b1;
  assign aaddr   = aaddr_r;
  assign adata   = adata_r;
  assign wr_off  = wr_off_r;
  assign busy    = (state_r != ST_IDLE);
  assign full    = full_s;

`ifdef SAMPLE_DMA_WATERMARK_EN
  logic [AW-1:0] fill_s;
  logic          wm_hit_r;

  assign fill_s = (wr_off_r - rd_off) & mask_s;

  // Watermark flag, refreshed every cycle from the current fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wm_hit_r <= 1'b0;
    end else begin
      wm_hit_r <= (fill_s >= wm_level);
    end
  end

  assign wm_hit = wm_hit_r;
`else
  logic unused_wm_level_s;

  assign unused_wm_level_s = ^wm_level;
  assign wm_hit            = 1'b0;
`endif

endmodule

// File: tb/tb_sample_dma.sv
// Randomised, self-checking bench for sample_dma against a ring-buffer model.
// Honours SAMPLE_DMA_WATERMARK_EN for the wm_hit expectation.
module tb_sample_dma;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] base;
  logic [4:0]    size_log2;
  logic [AW-1:0] rd_off;
  logic [AW-1:0] wm_level;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [15:0]   fifo_data;
  logic          avalid;
  logic          aready;
  logic          awe;
  logic [AW-1:0] aaddr;
  logic [15:0]   adata;
  logic [AW-1:0] wr_off;
  logic          busy;
  logic          full;
  logic          wm_hit;

  sample_dma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .base(base), .size_log2(size_log2),
    .rd_off(rd_off), .wm_level(wm_level), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .avalid(avalid),
    .aready(aready), .awe(awe), .aaddr(aaddr), .adata(adata),
    .wr_off(wr_off), .busy(busy), .full(full), .wm_hit(wm_hit)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc = -1;
  int stall_left = 0;
  bit aready_rand = 1'b0;
  bit gap_chk = 1'b0;
  bit en_prev = 1'b0;
  logic [AW-1:0] wo;          // model of the producer offset
  logic [15:0] fq[$];         // words still inside the sample FIFO
  logic [15:0] exp_q[$];      // words read out, in the order they must be written

  task automatic push(input logic [15:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: predict the edge outcome, take the edge, compare, drive next inputs.
  task automatic cycle();
    longint sz;
    logic [AW-1:0] wo_next;
    logic [AW-1:0] h_a;
    logic [15:0] h_d;
    logic [15:0] d;
    bit exp_wm;
    bit exp_full;
    bit took_rd;
    bit hold;
    sz = longint'(1) << size_log2;
    wo_next = wo;
    if (avalid === 1'b1 && aready === 1'b1) begin
      checks++;
      if (aaddr !== (base | wo)) begin
        errors++;
        $display("FAIL write_addr cyc=%0d actual=%h expected=%h", cyc, aaddr, base | wo);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_data cyc=%0d actual=%h expected=no_word_pending", cyc, adata);
      end else begin
        d = exp_q.pop_front();
        if (adata !== d) begin
          errors++;
          $display("FAIL write_data cyc=%0d actual=%h expected=%h", cyc, adata, d);
        end
      end
      if (gap_chk && last_acc >= 0) begin
        checks++;
        if (cyc - last_acc != 4) begin
          errors++;
          $display("FAIL throughput_gap cyc=%0d actual=%0d expected=4", cyc, cyc - last_acc);
        end
      end
      last_acc = cyc;
      n_acc++;
      wo_next = AW'((longint'(wo) + 64'sd1) % sz);
    end
    if (en && !en_prev) wo_next = '0;
`ifdef SAMPLE_DMA_WATERMARK_EN
    exp_wm = (((longint'(wo) % sz) - (longint'(rd_off) % sz) + sz) % sz) >= longint'(wm_level);
`else
    exp_wm = 1'b0;
`endif
    took_rd = (fifo_rd === 1'b1);
    hold = (avalid === 1'b1) && (aready === 1'b0);
    h_a = aaddr;
    h_d = adata;
    en_prev = en;
    @(posedge clk);
    #1;
    cyc++;
    wo = wo_next;
    checks++;
    if (wr_off !== wo) begin
      errors++;
      $display("FAIL wr_off cyc=%0d actual=%h expected=%h", cyc, wr_off, wo);
    end
    exp_full = (((longint'(wo) + 64'sd1) % sz) == (longint'(rd_off) % sz));
    checks++;
    if (full !== exp_full) begin
      errors++;
      $display("FAIL full cyc=%0d actual=%b expected=%b", cyc, full, exp_full);
    end
    checks++;
    if (wm_hit !== exp_wm) begin
      errors++;
      $display("FAIL wm_hit cyc=%0d actual=%b expected=%b", cyc, wm_hit, exp_wm);
    end
    if (hold) begin
      checks++;
      if (avalid !== 1'b1 || aaddr !== h_a || adata !== h_d) begin
        errors++;
        $display("FAIL req_stable cyc=%0d actual=%b/%h/%h expected=1/%h/%h",
                 cyc, avalid, aaddr, adata, h_a, h_d);
      end
    end
    if (took_rd) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underrun cyc=%0d actual=read expected=no_read", cyc);
        fifo_data = 16'($urandom);
      end else begin
        d = fq.pop_front();
        exp_q.push_back(d);
        fifo_data = d;
      end
    end else begin
      fifo_data = 16'($urandom);
    end
    fifo_empty = (fq.size() == 0);
    if (stall_left > 0 && avalid === 1'b1) begin
      aready = 1'b0;
      stall_left--;
    end else begin
      aready = aready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic run_until_acc(input int target, input int limit, input string tag);
    int i;
    for (i = 0; i < limit && n_acc < target; i++) cycle();
    checks++;
    if (n_acc < target) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d expected=%0d writes", tag, n_acc, target);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    aready = 1'b1;
    stall_left = 0;
    aready_rand = 1'b0;
    gap_chk = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wo = '0;
    en_prev = 1'b0;
    exp_q.delete();
    fq.delete();
    fifo_empty = 1'b1;
    n_acc = 0;
    last_acc = -1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (avalid !== 1'b0 || fifo_rd !== 1'b0 || busy !== 1'b0 || wr_off !== '0 || wm_hit !== 1'b0) begin
      errors++;
      $display("FAIL %s actual=avalid%b/rd%b/busy%b/wr%h/wm%b expected=0/0/0/0/0",
               tag, avalid, fifo_rd, busy, wr_off, wm_hit);
    end
  endtask

  task automatic test_reset();
    base = 24'h000100; size_log2 = 5'd4; rd_off = '0; wm_level = 24'd1;
    do_reset();
    check_idle_outputs("reset_state");
    checks++;
    if (adata !== 16'h0000 || awe !== 1'b1) begin
      errors++;
      $display("FAIL reset_data actual=%h/%b expected=0000/1", adata, awe);
    end
  endtask

  task automatic test_basic();
    do_reset();
    base = 24'h000100; size_log2 = 5'd4; rd_off = '0; wm_level = 24'd2;
    push(16'h1111); push(16'h2222); push(16'h3333);
    en = 1'b1;
    run_until_acc(3, 60, "basic");
    run_cycles(6);
    checks++;
    if (wr_off !== 24'd3 || busy !== 1'b0 || n_acc != 3) begin
      errors++;
      $display("FAIL basic_end actual=wr%h/busy%b/n%0d expected=3/0/3", wr_off, busy, n_acc);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    base = 24'h000000; size_log2 = 5'd2; rd_off = '0; wm_level = 24'd3;
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i));
    en = 1'b1;
    run_cycles(60);
    checks++;
    if (n_acc != 3 || full !== 1'b1 || fq.size() != 2) begin
      errors++;
      $display("FAIL full_stall actual=n%0d/full%b/left%0d expected=3/1/2", n_acc, full, fq.size());
    end
    rd_off = 24'd2;
    run_until_acc(5, 60, "wrap");
    run_cycles(10);
    checks++;
    if (n_acc != 5 || wr_off !== 24'd1 || full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end actual=n%0d/wr%h/full%b expected=5/1/1", n_acc, wr_off, full);
    end
  endtask

  task automatic test_stall();
    do_reset();
    base = 24'h004000; size_log2 = 5'd6; rd_off = '0; wm_level = 24'd0;
    push(16'h5A5A);
    stall_left = 10;
    en = 1'b1;
    run_until_acc(1, 40, "stall");
    run_cycles(8);
    checks++;
    if (n_acc != 1 || stall_left != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_single actual=n%0d/stall%0d expected=1/0", n_acc, stall_left);
    end
  endtask

  task automatic test_en_drop();
    int i;
    do_reset();
    base = 24'h000200; size_log2 = 5'd3; rd_off = '0; wm_level = 24'd5;
    push(16'hBEEF); push(16'hCAFE);
    en = 1'b1;
    for (i = 0; i < 30 && fifo_rd !== 1'b1; i++) cycle();
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_fetch actual=%b expected=1", fifo_rd);
    end
    cycle();
    en = 1'b0;
    run_cycles(20);
    checks++;
    if (n_acc != 1 || busy !== 1'b0 || fq.size() != 1 || wr_off !== 24'd1) begin
      errors++;
      $display("FAIL en_drop_end actual=n%0d/busy%b/left%0d/wr%h expected=1/0/1/1",
               n_acc, busy, fq.size(), wr_off);
    end
    en = 1'b1;
    cycle();
    checks++;
    if (wr_off !== 24'd0) begin
      errors++;
      $display("FAIL en_rise_clear actual=%h expected=0", wr_off);
    end
    run_until_acc(2, 40, "en_restart");
  endtask

  task automatic test_watermark();
    bit exp_hit;
    do_reset();
    base = 24'h000300; size_log2 = 5'd4; rd_off = '0; wm_level = 24'd4;
    for (int i = 0; i < 6; i++) push(16'(16'h0C00 + i));
    en = 1'b1;
    run_until_acc(4, 80, "wm");
    cycle();
`ifdef SAMPLE_DMA_WATERMARK_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    checks++;
    if (wm_hit !== exp_hit) begin
      errors++;
      $display("FAIL wm_after_4 actual=%b expected=%b", wm_hit, exp_hit);
    end
    run_until_acc(6, 60, "wm_rest");
  endtask

  task automatic test_back_to_back();
    do_reset();
    base = 24'h001000; size_log2 = 5'd5; rd_off = '0; wm_level = 24'd3;
    for (int i = 0; i < 6; i++) push(16'($urandom));
    gap_chk = 1'b1;
    en = 1'b1;
    run_until_acc(6, 60, "b2b");
    gap_chk = 1'b0;
  endtask

  task automatic test_reset_mid();
    int i;
    do_reset();
    base = 24'h000500; size_log2 = 5'd4; rd_off = '0; wm_level = 24'd9;
    push(16'h7777); push(16'h8888);
    stall_left = 1000;
    en = 1'b1;
    for (i = 0; i < 30 && avalid !== 1'b1; i++) cycle();
    run_cycles(2);
    checks++;
    if (avalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_reach actual=%b expected=1", avalid);
    end
    do_reset();
    check_idle_outputs("reset_mid_write");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      size_log2 = 5'($urandom_range(2, 6));
      base = AW'($urandom) << size_log2;
      rd_off = AW'($urandom);
      wm_level = AW'($urandom_range(0, 40));
      for (int i = 0; i < 12; i++) push(16'($urandom));
      aready_rand = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 250; c++) begin
        if (c % 16 == 15) rd_off = AW'($urandom);
        cycle();
      end
      aready_rand = 1'b0;
      en = 1'b0;
      run_cycles(10);
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_drain round=%0d actual=busy%b/inflight%0d expected=0/0", r, busy, exp_q.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; base = '0; size_log2 = 5'd4; rd_off = '0; wm_level = '0;
    fifo_empty = 1'b1; fifo_data = 16'h0000; aready = 1'b1; wo = '0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_stall();
    test_en_drop();
    test_watermark();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
